ks_byte_serializer: RTL and testbench



---
 rtl/ks_ser_pkg.sv | 19 +
 rtl/ks_byte_serializer.sv | 130 +++++++++++++
 tb/tb_ks_byte_serializer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ks_ser_pkg.sv
// Shared types and constants for the keystream byte serializer.
package ks_ser_pkg;

  localparam int KS_BLOCK_BYTES = 64;
  localparam int KS_WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_CKSUM = 2'd2,
    ST_DONE  = 2'd3
  } ks_state_e;

  // A one-byte block still needs a 1-bit index register.
  function automatic int ks_idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/ks_byte_serializer.sv
// Captures one keystream block and streams it to the UART TX byte-by-byte (LSB-first per word).
// Define KS_SER_CKSUM_EN to append one XOR checksum byte after the data bytes.
module ks_byte_serializer
  import ks_ser_pkg::*;
#(
  parameter int BLOCK_BYTES = KS_BLOCK_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ks_valid,
  input  logic [8*BLOCK_BYTES-1:0] ks_data,
  output logic                     ks_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     led_done
);

  localparam int               IDX_W    = ks_idx_width(BLOCK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

  ks_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [8*BLOCK_BYTES-1:0] blk_q;
  logic                     led_done_q, led_done_d;
  logic                     capture;
  logic [7:0]               data_byte;
`ifdef KS_SER_CKSUM_EN
  logic [7:0]               cksum_q, cksum_d;
`endif

  // Word i occupies blk[32i +: 32], so a flat byte index already gives LSB-first order per word.
  assign data_byte = blk_q[idx_q*8 +: 8];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    led_done_d = led_done_q;
    capture    = 1'b0;
    ks_ready   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
`ifdef KS_SER_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ks_ready = 1'b1;
        if (ks_valid) begin
          capture    = 1'b1;
          idx_d      = '0;
          led_done_d = 1'b0;
`ifdef KS_SER_CKSUM_EN
          cksum_d    = 8'h00;
`endif
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
`ifdef KS_SER_CKSUM_EN
          cksum_d = cksum_q ^ data_byte;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef KS_SER_CKSUM_EN
            state_d    = ST_CKSUM;
`else
            state_d    = ST_DONE;
            led_done_d = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef KS_SER_CKSUM_EN
      ST_CKSUM: begin
        tx_valid = 1'b1;
        tx_data  = cksum_q;
        if (tx_ready) begin
          state_d    = ST_DONE;
          led_done_d = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        // Core 'done' may be a level; require it to drop before accepting another block.
        if (!ks_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      led_done_q <= 1'b0;
`ifdef KS_SER_CKSUM_EN
      cksum_q    <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      led_done_q <= led_done_d;
`ifdef KS_SER_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
    end else if (capture) begin
      blk_q <= ks_data;
    end
  end

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign led_done = led_done_q;

endmodule

// File: tb/tb_ks_byte_serializer.sv
// Directed scoreboard bench for ks_byte_serializer (checksum byte expected when KS_SER_CKSUM_EN is defined).
module tb_ks_byte_serializer;
  import ks_ser_pkg::*;

  localparam int NB = KS_BLOCK_BYTES;
`ifdef KS_SER_CKSUM_EN
  localparam int NSENT = NB + 1;
  localparam bit CK    = 1'b1;
`else
  localparam int NSENT = NB;
  localparam bit CK    = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ks_valid = 1'b0;
  logic          tx_ready = 1'b0;
  logic [8*NB-1:0] ks_data = '0;
  logic          ks_ready, tx_valid, busy, led_done;
  logic [7:0]    tx_data;

  ks_byte_serializer #(.BLOCK_BYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ks_valid (ks_valid),
    .ks_data  (ks_data),
    .ks_ready (ks_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .led_done (led_done)
  );

  always #10 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         xfers = 0;
  logic [7:0] sb_q[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8*NB-1:0] ramp, blk_a, blk_b, sparse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream built from the word view: word w, lane l -> byte 4w+l.
  task automatic push_block(input logic [8*NB-1:0] b);
    logic [31:0] w;
    logic [7:0]  by;
    logic [7:0]  x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      w  = b[32*(k/KS_WORD_BYTES) +: 32];
      by = w[8*(k%KS_WORD_BYTES) +: 8];
      sb_q.push_back(by);
      x = x ^ by;
    end
    if (CK) sb_q.push_back(x);
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [7:0] exp_b;
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall && tx_valid) chk("hold_data", {24'h0, tx_data}, {24'h0, prev_data});
      if (tx_valid && tx_ready) begin
        chk("sb_has_expected", {31'h0, (sb_q.size() > 0)}, 32'h1);
        if (sb_q.size() > 0) begin
          exp_b = sb_q.pop_front();
          $display("xfer %0d: tx_data=%02h expected=%02h", xfers, tx_data, exp_b);
          chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_b});
        end
        xfers++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (!led_done && n < budget) begin
      cycle();
      n++;
    end
    chk("done_in_budget", {31'h0, led_done}, 32'h1);
  endtask

  initial begin
    for (int k = 0; k < NB; k++) ramp[8*k +: 8] = 8'(k);
    for (int w = 0; w < NB/4; w++) begin
      blk_a[32*w +: 32] = $urandom;
      blk_b[32*w +: 32] = $urandom;
    end
    sparse = '0;
    sparse[8*5 +: 8] = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ks_ready", {31'h0, ks_ready}, 32'h1);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_led_done", {31'h0, led_done}, 32'h0);
    rst_n = 1'b1;

    // Ramp block, tx_ready held high: no bubbles
    ks_data = ramp; ks_valid = 1'b1; tx_ready = 1'b1;
    push_block(ramp); xfers = 0;
    cycle();
    ks_valid = 1'b0;
    chk("cap_busy", {31'h0, busy}, 32'h1);
    chk("cap_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("cap_byte0", {24'h0, tx_data}, 32'h0);
    chk("cap_ks_ready", {31'h0, ks_ready}, 32'h0);
    for (int i = 0; i < NSENT; i++) begin
      chk("pre_last_led", {31'h0, led_done}, 32'h0);
      cycle();
      chk("consecutive", xfers, i + 1);
    end
    chk("ramp_led_done", {31'h0, led_done}, 32'h1);
    chk("ramp_tx_valid_off", {31'h0, tx_valid}, 32'h0);
    chk("ramp_busy_off", {31'h0, busy}, 32'h0);
    chk("ramp_sb_empty", sb_q.size(), 0);
    cycle();
    chk("back_to_idle", {31'h0, ks_ready}, 32'h1);

    // Same block, tx_ready pulsed once every 434 cycles
    ks_data = ramp; ks_valid = 1'b1; tx_ready = 1'b0;
    push_block(ramp); xfers = 0;
    cycle();
    ks_valid = 1'b0;
    chk("led_cleared_at_capture", {31'h0, led_done}, 32'h0);
    for (int c = 0; !led_done && c < NSENT*434 + 100; c++) begin
      tx_ready = ((c % 434) == 433);
      cycle();
    end
    tx_ready = 1'b0;
    chk("slow_done", {31'h0, led_done}, 32'h1);
    chk("slow_count", xfers, NSENT);
    chk("slow_sb_empty", sb_q.size(), 0);
    cycle();

    // ks_valid held as a level: exactly one block, then DONE holds
    ks_data = blk_a; ks_valid = 1'b1; tx_ready = 1'b1;
    push_block(blk_a); xfers = 0;
    cycle();
    run_to_done(NSENT + 10);
    repeat (1000) cycle();
    chk("level_count", xfers, NSENT);
    chk("level_busy", {31'h0, busy}, 32'h0);
    chk("level_ks_ready", {31'h0, ks_ready}, 32'h0);
    chk("level_led", {31'h0, led_done}, 32'h1);

    // Re-arm; ks_data changes right after capture and must not leak in
    ks_valid = 1'b0;
    cycle();
    ks_data = blk_b; ks_valid = 1'b1;
    push_block(blk_b); xfers = 0;
    cycle();
    ks_data = ~blk_b;
    chk("second_led_cleared", {31'h0, led_done}, 32'h0);
    run_to_done(NSENT + 10);
    chk("second_count", xfers, NSENT);
    chk("second_sb_empty", sb_q.size(), 0);
    ks_valid = 1'b0;
    cycle();

    // Reset after byte 20 is accepted
    ks_data = ramp; ks_valid = 1'b1; tx_ready = 1'b1;
    push_block(ramp); xfers = 0;
    cycle();
    for (int n = 0; xfers < 21 && n < 100; n++) cycle();
    chk("pre_reset_xfers", xfers, 21);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_led_done", {31'h0, led_done}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("arst_ks_ready", {31'h0, ks_ready}, 32'h1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_block(ramp); xfers = 0;
    cycle();
    ks_valid = 1'b0;
    chk("restart_byte0", {24'h0, tx_data}, 32'h0);
    run_to_done(NSENT + 10);
    chk("restart_count", xfers, NSENT);
    chk("restart_sb_empty", sb_q.size(), 0);
    cycle();

    // Sparse block: checksum byte (when present) is 0x5A
    ks_data = sparse; ks_valid = 1'b1;
    push_block(sparse); xfers = 0;
    cycle();
    ks_valid = 1'b0;
    run_to_done(NSENT + 10);
    chk("sparse_count", xfers, NSENT);
    chk("sparse_sb_empty", sb_q.size(), 0);
    repeat (5) cycle();
    chk("sparse_no_extra", xfers, NSENT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
